// File: rtl/nh_lcd_data_reader_pkg.sv
// nh_lcd_data_reader_pkg: shared constants and state encoding for the NH LCD read path.
//   CMD_START_MEM_READ - panel command byte that starts a memory read (8'h2E)
//   state_e            - reader FSM state encoding (4 bits, mirrored on debug[7:4])
//   SlotBlue           - byte slot index of the last byte of a pixel
package nh_lcd_data_reader_pkg;

  localparam logic [7:0] CMD_START_MEM_READ = 8'h2E;

  localparam logic [1:0] SlotRed   = 2'd0;
  localparam logic [1:0] SlotGreen = 2'd1;
  localparam logic [1:0] SlotBlue  = 2'd2;

  typedef enum logic [3:0] {
    StIdle        = 4'd0,
    StCmd         = 4'd1,
    StTurnaround  = 4'd2,
    StDummyRd     = 4'd3,
    StDummySample = 4'd4,
    StRd          = 4'd5,
    StSample      = 4'd6,
    StWaitOut     = 4'd7,
    StFinish      = 4'd8,
    StWaitDisable = 4'd9
  } state_e;

endpackage

// File: rtl/nh_lcd_data_reader_if.sv
// nh_lcd_data_reader_if: panel bus plus outgoing pixel stream of the LCD data reader.
//   master modport (reader side):
//     o_cmd_mode     0 = command byte on bus, 1 = data
//     o_data_out     bus drive value
//     i_data_in      bus sample value
//     o_write        one-cycle write strobe
//     o_read         one-cycle read strobe
//     o_data_out_en  1 = controller drives the bus
//     o_pixel_valid  o_pixel_data holds an unaccepted pixel
//     i_pixel_ready  consumer accepts when valid & ready at the clock edge
//     o_pixel_data   {red, green, blue}
//   slave modport: panel / consumer side, directions reversed.
interface nh_lcd_data_reader_if;

  logic        o_cmd_mode;
  logic [7:0]  o_data_out;
  logic [7:0]  i_data_in;
  logic        o_write;
  logic        o_read;
  logic        o_data_out_en;
  logic        o_pixel_valid;
  logic        i_pixel_ready;
  logic [23:0] o_pixel_data;

  modport master (
    output o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en,
    output o_pixel_valid, o_pixel_data,
    input  i_data_in, i_pixel_ready
  );

  modport slave (
    input  o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en,
    input  o_pixel_valid, o_pixel_data,
    output i_data_in, i_pixel_ready
  );

endinterface

// File: rtl/nh_lcd_pixel_packer.sv
// nh_lcd_pixel_packer: assembles R, G, B bus bytes into one 24-bit pixel and holds it in a
// valid/ready output register until the consumer takes it.
//   clk, rst     system clock, synchronous active-high reset
//   clear        drop any held pixel and restart at the red slot (transaction abort)
//   capture      store data_in into the current byte slot and advance the slot
//   load         move {R,G,B} into the output register and raise pixel_valid
//   data_in      bus byte to capture
//   pixel_ready  consumer ready
//   slot         current byte slot (0 = R, 1 = G, 2 = B)
//   can_load     output register is empty or being emptied this cycle
//   pixel_valid  output register holds an unaccepted pixel
//   pixel_data   {red, green, blue}
module nh_lcd_pixel_packer
  import nh_lcd_data_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        capture,
  input  logic        load,
  input  logic [7:0]  data_in,
  input  logic        pixel_ready,
  output logic [1:0]  slot,
  output logic        can_load,
  output logic        pixel_valid,
  output logic [23:0] pixel_data
);

  logic [1:0]  slot_q;
  logic [7:0]  red_q, green_q, blue_q;
  logic        valid_q;
  logic [23:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= SlotRed;
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
      valid_q <= 1'b0;
      data_q  <= 24'h000000;
    end else if (clear) begin
      slot_q  <= SlotRed;
      valid_q <= 1'b0;
    end else begin
      if (capture) begin
        unique case (slot_q)
          SlotRed:   red_q   <= data_in;
          SlotGreen: green_q <= data_in;
          default:   blue_q  <= data_in;
        endcase
        slot_q <= (slot_q == SlotBlue) ? SlotRed : slot_q + 2'd1;
      end
      // A load in the same cycle as an acceptance replaces the pixel being taken.
      if (load) begin
        data_q  <= {red_q, green_q, blue_q};
        valid_q <= 1'b1;
      end else if (valid_q && pixel_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign slot        = slot_q;
  assign can_load    = !valid_q || pixel_ready;
  assign pixel_valid = valid_q;
  assign pixel_data  = data_q;

endmodule

// File: rtl/nh_lcd_data_reader.sv
// nh_lcd_data_reader: reads pixels back from the NH LCD panel over the 8-bit 8080 bus.
// Issues the memory-read command, turns the bus around, strobes out R, G, B bytes and
// streams packed 24-bit pixels on a valid/ready interface.
//   clk, rst       system clock, synchronous active-high reset
//   i_enable       start/hold a transaction; low aborts
//   i_num_pixels   pixels to read per transaction
//   o_busy         high from command issue until done/abort
//   o_done         one-cycle pulse after the last pixel is accepted
//   debug          [0] i_enable, [1] cmd_mode, [2] write, [3] read, [7:4] state,
//                  [8] pixel_valid, [9] data_out_en
//   bus            panel bus and pixel stream (master modport)
// Optional feature: NH_LCD_DUMMY_READ_EN inserts one discarded read after turnaround.
module nh_lcd_data_reader
  import nh_lcd_data_reader_pkg::*;
#(
  parameter int unsigned PIXEL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enable,
  input  logic [PIXEL_CNT_WIDTH-1:0] i_num_pixels,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [31:0]                debug,
  nh_lcd_data_reader_if.master       bus
);

  state_e state_q, state_d;

  logic                       cmd_mode_q, cmd_mode_d;
  logic                       write_q, write_d;
  logic                       read_q, read_d;
  logic [7:0]                 data_out_q, data_out_d;
  logic                       data_out_en_q, data_out_en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [PIXEL_CNT_WIDTH-1:0] count_q, count_d, count_inc;

  logic        pk_clear, pk_capture, pk_load;
  logic [1:0]  pk_slot;
  logic        pk_can_load;
  logic        pk_valid;
  logic [23:0] pk_data;
  logic        in_transaction;

  nh_lcd_pixel_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pk_clear),
    .capture     (pk_capture),
    .load        (pk_load),
    .data_in     (bus.i_data_in),
    .pixel_ready (bus.i_pixel_ready),
    .slot        (pk_slot),
    .can_load    (pk_can_load),
    .pixel_valid (pk_valid),
    .pixel_data  (pk_data)
  );

  assign count_inc      = count_q + PIXEL_CNT_WIDTH'(1);
  assign in_transaction = (state_q != StIdle) && (state_q != StWaitDisable);

  always_comb begin
    state_d       = state_q;
    cmd_mode_d    = 1'b1;
    write_d       = 1'b0;
    read_d        = 1'b0;
    data_out_d    = data_out_q;
    data_out_en_d = data_out_en_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    count_d       = count_q;
    pk_clear      = 1'b0;
    pk_capture    = 1'b0;
    pk_load       = 1'b0;

    if (in_transaction && !i_enable) begin
      // Abort: release the bus and drop any pending pixel without signalling done.
      state_d       = StIdle;
      data_out_en_d = 1'b1;
      busy_d        = 1'b0;
      count_d       = '0;
      pk_clear      = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_enable) begin
            state_d = (i_num_pixels != '0) ? StCmd : StFinish;
          end
        end
        StCmd: begin
          cmd_mode_d = 1'b0;
          write_d    = 1'b1;
          data_out_d = CMD_START_MEM_READ;
          busy_d     = 1'b1;
          state_d    = StTurnaround;
        end
        StTurnaround: begin
          data_out_en_d = 1'b0;
`ifdef NH_LCD_DUMMY_READ_EN
          state_d = StDummyRd;
`else
          state_d = StRd;
`endif
        end
`ifdef NH_LCD_DUMMY_READ_EN
        StDummyRd: begin
          read_d  = 1'b1;
          state_d = StDummySample;
        end
        StDummySample: begin
          state_d = StRd;
        end
`endif
        StRd: begin
          read_d  = 1'b1;
          state_d = StSample;
        end
        StSample: begin
          pk_capture = 1'b1;
          state_d    = (pk_slot == SlotBlue) ? StWaitOut : StRd;
        end
        StWaitOut: begin
          if (pk_can_load) begin
            pk_load = 1'b1;
            count_d = count_inc;
            // >= so that shrinking i_num_pixels mid-transaction still terminates.
            state_d = (count_inc >= i_num_pixels) ? StFinish : StRd;
          end
        end
        StFinish: begin
          if (!pk_valid) begin
            done_d        = 1'b1;
            data_out_en_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = StWaitDisable;
          end
        end
        StWaitDisable: begin
          if (!i_enable) begin
            state_d = StIdle;
            count_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cmd_mode_q    <= 1'b1;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      data_out_q    <= CMD_START_MEM_READ;
      data_out_en_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_mode_q    <= cmd_mode_d;
      write_q       <= write_d;
      read_q        <= read_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      count_q       <= count_d;
    end
  end

  assign bus.o_cmd_mode    = cmd_mode_q;
  assign bus.o_write       = write_q;
  assign bus.o_read        = read_q;
  assign bus.o_data_out    = data_out_q;
  assign bus.o_data_out_en = data_out_en_q;
  assign bus.o_pixel_valid = pk_valid;
  assign bus.o_pixel_data  = pk_data;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

  assign debug = {22'd0, data_out_en_q, pk_valid, 4'(state_q), read_q, write_q, cmd_mode_q,
                  i_enable};

endmodule
